// File: rtl/bfp32_add_arbiter.sv
// rtl/bfp32_add_arbiter.sv - round-robin arbiter sharing one pipelined bfp32 adder
// Optional transfer/stall counters are built when BFP_ARB_STAT_EN is defined.
module bfp32_add_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADD_LAT = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*32-1:0]      req_a,
   input  logic [NUM_REQ*32-1:0]      req_b,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [31:0]                add_a,
   output logic [31:0]                add_b,
   input  logic [31:0]                add_o,
   output logic                       res_valid,
   output logic [$clog2(NUM_REQ)-1:0] res_id,
   output logic [31:0]                res_data,
   output logic                       busy
`ifdef BFP_ARB_STAT_EN
   ,
   output logic [31:0]                issue_cnt,
   output logic [31:0]                stall_cnt
`endif
);

   localparam int ID_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [ID_W-1:0]   r_ptr;
   logic [ID_W-1:0]   w_ptr_nxt;
   logic [ID_W-1:0]   w_gnt_id;
   logic [ID_W-1:0]   w_scan_idx;
   logic              w_gnt_found;
   logic              w_xfer;
   logic [31:0]       w_sel_a;
   logic [31:0]       w_sel_b;

   logic [31:0]       r_add_a;
   logic [31:0]       r_add_b;

   logic [ADD_LAT:0]  r_tag_v;
   logic [ID_W-1:0]   r_tag_id [0:ADD_LAT];
   logic              w_tags_busy;

   logic              r_res_valid;
   logic [ID_W-1:0]   r_res_id;
   logic [31:0]       r_res_data;

   // First valid requester at or after the priority pointer, wrapping.
   always_comb begin
      w_gnt_found = 1'b0;
      w_gnt_id    = '0;
      w_scan_idx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_scan_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
         if (!w_gnt_found && req_valid[w_scan_idx]) begin
            w_gnt_found = 1'b1;
            w_gnt_id    = w_scan_idx;
         end
      end
   end

   assign w_xfer = en & w_gnt_found;

   always_comb begin
      w_sel_a   = '0;
      w_sel_b   = '0;
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_gnt_id == ID_W'(i)) begin
            w_sel_a = req_a[32*i +: 32];
            w_sel_b = req_b[32*i +: 32];
         end
         req_ready[i] = w_xfer && (w_gnt_id == ID_W'(i));
      end
   end

   assign w_ptr_nxt = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : (w_gnt_id + ID_W'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr   <= '0;
         r_add_a <= '0;
         r_add_b <= '0;
      end else if (w_xfer) begin
         r_ptr   <= w_ptr_nxt;
         r_add_a <= w_sel_a;
         r_add_b <= w_sel_b;
      end
   end

   // Tag pipeline runs in lockstep with the adder; it never stalls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tag_v <= '0;
         for (int i = 0; i <= ADD_LAT; i++) begin
            r_tag_id[i] <= '0;
         end
      end else begin
         r_tag_v     <= {r_tag_v[ADD_LAT-1:0], w_xfer};
         r_tag_id[0] <= w_gnt_id;
         for (int i = 1; i <= ADD_LAT; i++) begin
            r_tag_id[i] <= r_tag_id[i-1];
         end
      end
   end

   assign w_tags_busy = |r_tag_v;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_res_valid <= 1'b0;
         r_res_id    <= '0;
         r_res_data  <= '0;
      end else begin
         r_res_valid <= r_tag_v[ADD_LAT];
         if (r_tag_v[ADD_LAT]) begin
            r_res_id   <= r_tag_id[ADD_LAT];
            r_res_data <= add_o;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // An empty tag pipeline while draining means the last result is on res_* now.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_xfer) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (!w_xfer) begin
               w_state_nxt = w_tags_busy ? S_DRAIN : S_IDLE;
            end
         end
         S_DRAIN: begin
            if (w_xfer) begin
               w_state_nxt = S_RUN;
            end else if (!w_tags_busy) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign add_a     = r_add_a;
   assign add_b     = r_add_b;
   assign res_valid = r_res_valid;
   assign res_id    = r_res_id;
   assign res_data  = r_res_data;
   assign busy      = (r_state != S_IDLE);

`ifdef BFP_ARB_STAT_EN
   logic [31:0] r_issue_cnt;
   logic [31:0] r_stall_cnt;

   // Issue count wraps; stall count saturates.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_issue_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_xfer) begin
            r_issue_cnt <= r_issue_cnt + 32'd1;
         end
         if ((|req_valid) && !w_xfer && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
      end
   end

   assign issue_cnt = r_issue_cnt;
   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_bfp32_add_arbiter.sv
// tb/tb_bfp32_add_arbiter.sv - scoreboard bench for bfp32_add_arbiter
// Includes a 2-stage behavioural bfp32 adder; counter checks when BFP_ARB_STAT_EN is defined.
module tb_bfp32_add_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ADD_LAT = 2;
   localparam int ID_W    = 2;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   en;
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ*32-1:0]  req_a;
   logic [NUM_REQ*32-1:0]  req_b;
   logic [NUM_REQ-1:0]     req_ready;
   logic [31:0]            add_a;
   logic [31:0]            add_b;
   logic [31:0]            add_o;
   logic                   res_valid;
   logic [ID_W-1:0]        res_id;
   logic [31:0]            res_data;
   logic                   busy;
`ifdef BFP_ARB_STAT_EN
   logic [31:0]            issue_cnt;
   logic [31:0]            stall_cnt;
   logic [31:0]            base_issue;
   logic [31:0]            base_stall;
`endif

   bfp32_add_arbiter #(.NUM_REQ(NUM_REQ), .ADD_LAT(ADD_LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_o     (add_o),
      .res_valid (res_valid),
      .res_id    (res_id),
      .res_data  (res_data),
      .busy      (busy)
`ifdef BFP_ARB_STAT_EN
      ,
      .issue_cnt (issue_cnt),
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int n_res    = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      d = $realtobits(r);
      if (d[62:0] == 63'd0) return {d[63], 31'd0};
      return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
   endfunction

   function automatic real f2r(input logic [31:0] f);
      logic [63:0] d;
      if (f[30:0] == 31'd0) d = {f[31], 63'd0};
      else                  d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      return r2f(f2r(a) + f2r(b));
   endfunction

   logic [31:0] adder_s1;
   always @(posedge clk) begin
      adder_s1 <= fadd(add_a, add_b);
      add_o    <= adder_s1;
   end

   typedef struct {
      logic [ID_W-1:0] id;
      logic [31:0]     data;
   } exp_t;

   exp_t sb_q[$];
   exp_t sb_e;

   always @(negedge rst) sb_q.delete();

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (res_valid) begin
            n_res++;
            if (sb_q.size() == 0) begin
               check("sb_unexpected", 64'd1, 64'd0);
            end else begin
               sb_e = sb_q.pop_front();
               check("sb_id", res_id, sb_e.id);
               check("sb_data", res_data, sb_e.data);
            end
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               sb_q.push_back('{id: ID_W'(i), data: fadd(req_a[32*i +: 32], req_b[32*i +: 32])});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
   endtask

   task automatic wait_drain(input string tag);
      for (int k = 0; k < 40 && (busy || sb_q.size() != 0); k++) tick();
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_queue"}, sb_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int base;

   initial begin
      rst = 1'b0; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_add_a", add_a, 0);
      check("rst_add_b", add_b, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_id", res_id, 0);
      check("rst_res_data", res_data, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", req_ready, 0);
`ifdef BFP_ARB_STAT_EN
      check("rst_issue_cnt", issue_cnt, 0);
      check("rst_stall_cnt", stall_cnt, 0);
`endif
      rst = 1'b1;
      tick();

      // All four requesters continuously valid
      en = 1'b1;
      base = n_res;
      for (int c = 0; c < 8; c++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            set_op(i, r2f(real'($urandom_range(1, 64))), r2f(real'($urandom_range(1, 64))));
         end
         req_valid = 4'hF;
         #1;
         check("rr_grant", req_ready, 4'b0001 << (c % 4));
         tick();
      end
      req_valid = '0;
      wait_drain("rr_drain");
      check("rr_count", n_res - base, 8);

      // Single request, fixed latency
      set_op(2, 32'h4000_0000, 32'h4040_0000);
      req_valid = 4'b0100;
      #1;
      check("single_ready", req_ready, 4'b0100);
      tick();
      check("single_add_a", add_a, 32'h4000_0000);
      check("single_add_b", add_b, 32'h4040_0000);
      req_valid = '0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         check("single_res_valid", res_valid, (k == 3));
      end
      check("single_res_id", res_id, 2);
      check("single_res_data", res_data, 32'h40A0_0000);
      check("single_busy_hi", busy, 1);
      tick();
      check("single_busy_lo", busy, 0);
      check("single_res_valid_lo", res_valid, 0);
      check("single_hold", res_data, 32'h40A0_0000);

      // Pointer wrap: move ptr to 1, then only requesters 0 and 3 valid
      set_op(0, r2f(1.0), r2f(2.0));
      set_op(3, r2f(7.0), r2f(8.0));
      req_valid = 4'b0001;
      #1;
      check("wrap_setup", req_ready, 4'b0001);
      tick();
      req_valid = 4'b1001;
      #1;
      check("wrap_first", req_ready, 4'b1000);
      tick();
      check("wrap_second", req_ready, 4'b0001);
      tick();
      req_valid = 4'b1111;
      #1;
      check("wrap_ptr1", req_ready, 4'b0010);
      req_valid = '0;
      wait_drain("wrap_drain");

      // en dropped with two ops in flight
      for (int i = 0; i < NUM_REQ; i++) set_op(i, r2f(real'(i + 1)), r2f(10.0));
      req_valid = 4'b1111;
      tick();
      tick();
      en = 1'b0;
      #1;
      check("drain_ready_en0", req_ready, 0);
      base = n_res;
      tick();
      check("drain_busy", busy, 1);
      check("drain_ready_hold", req_ready, 0);
      repeat (5) tick();
      check("drain_pulses", n_res - base, 2);
      check("drain_idle", busy, 0);
      req_valid = '0;
      en = 1'b1;
      wait_drain("drain_end");

      // Asynchronous reset one edge after a handshake
      set_op(2, r2f(4.0), r2f(6.0));
      req_valid = 4'b0100;
      #1;
      check("arst_ready", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      tick();
      rst = 1'b0;
      #1;
      check("arst_add_a", add_a, 0);
      check("arst_add_b", add_b, 0);
      check("arst_res_valid", res_valid, 0);
      check("arst_res_id", res_id, 0);
      check("arst_res_data", res_data, 0);
      check("arst_busy", busy, 0);
      tick();
      tick();
      rst = 1'b1;
      base = n_res;
      repeat (6) tick();
      check("arst_no_result", n_res - base, 0);
      check("arst_idle", busy, 0);

      // Lone requester granted every cycle, then blocked by en
`ifdef BFP_ARB_STAT_EN
      base_issue = issue_cnt;
      base_stall = stall_cnt;
`endif
      req_valid = 4'b0001;
      for (int c = 0; c < 3; c++) begin
         set_op(0, r2f(real'(c + 1)), r2f(0.5));
         #1;
         check("lone_grant", req_ready, 4'b0001);
         tick();
      end
      en = 1'b0;
      tick();
      tick();
      req_valid = '0;
      en = 1'b1;
`ifdef BFP_ARB_STAT_EN
      check("stat_issue", issue_cnt - base_issue, 3);
      check("stat_stall", stall_cnt - base_stall, 2);
`endif
      wait_drain("lone_drain");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
